// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write path.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] decode_wa(input logic [ADDR_W-1:0] wa);
    logic [NUM_REGS-1:0] onehot;
    onehot     = '0;
    onehot[wa] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Producer-side handshakes into the register-file write arbiter: WB pipe, load return, MDU.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic              pipe_valid;
  logic              pipe_ready;
  logic [ADDR_W-1:0] pipe_wa;
  logic [DATA_W-1:0] pipe_wd;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_wa;
  logic [DATA_W-1:0] ld_wd;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_wa;
  logic [DATA_W-1:0] mdu_wd;

  modport master (
    output pipe_valid, pipe_wa, pipe_wd, input pipe_ready,
    output ld_valid,   ld_wa,   ld_wd,   input ld_ready,
    output mdu_valid,  mdu_wa,  mdu_wd,  input mdu_ready
  );

  modport slave (
    input pipe_valid, pipe_wa, pipe_wd, output pipe_ready,
    input ld_valid,   ld_wa,   ld_wd,   output ld_ready,
    input mdu_valid,  mdu_wa,  mdu_wd,  output mdu_ready
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// In-order queue of register writes with up to two pushes per cycle (port a lands first)
// and per-entry visibility of valid/wa for pending-write mask generation.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_a,
  input  rf_wr_t                       push_a_data,
  input  logic                         push_b,
  input  rf_wr_t                       push_b_data,
  input  logic                         pop,
  output rf_wr_t                       head,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output logic [QDEPTH-1:0]            ent_valid,
  output logic [ADDR_W-1:0]            ent_wa [QDEPTH]
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH+1);

  rf_wr_t             mem_q [QDEPTH];
  rf_wr_t             mem_d [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == QDEPTH-1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push_a) begin
      mem_d[wr_ptr_d] = push_a_data;
      wr_ptr_d        = ptr_inc(wr_ptr_d);
    end
    if (push_b) begin
      mem_d[wr_ptr_d] = push_b_data;
      wr_ptr_d        = ptr_inc(wr_ptr_d);
    end
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; validity comes from the pointers and count, which are.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      ent_valid[i] = ((i - int'(rd_ptr_q) + QDEPTH) % QDEPTH) < int'(count_q);
      ent_wa[i]    = mem_q[i].wa;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges WB, load-return and MDU results onto the single register-file write port, with a
// shared in-order queue for load/MDU results, starvation back-pressure and a pending-write mask.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rf_write_arbiter_if.slave           wr,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_wa,
  output logic [DATA_W-1:0]           rf_wd,
  output logic [NUM_REGS-1:0]         pending_mask,
  output logic [$clog2(QDEPTH+1)-1:0] q_count
);

  localparam int CNT_W = $clog2(QDEPTH+1);
  localparam int SC_W  = $clog2(STARVE_MAX+1);

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              starve_flag_q, starve_flag_d;

  logic              pipe_wr, q_empty, pop, ld_push, mdu_push;
  rf_wr_t            fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [QDEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0] ent_wa [QDEPTH];

  // Free slots come from the registered count only, so a same-cycle pop never admits a push.
  assign wr.ld_ready   = int'(fifo_count) < QDEPTH;
  assign wr.mdu_ready  = (int'(fifo_count) + int'(wr.ld_valid)) < QDEPTH;
  assign wr.pipe_ready = !starve_flag_q;

  always_comb begin
    pipe_wr  = wr.pipe_valid && wr.pipe_ready && (wr.pipe_wa != '0);
    q_empty  = (fifo_count == '0);
    pop      = !pipe_wr && !q_empty;
    ld_push  = wr.ld_valid  && wr.ld_ready  && (wr.ld_wa  != '0);
    mdu_push = wr.mdu_valid && wr.mdu_ready && (wr.mdu_wa != '0);
  end

  rf_wr_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_a      (ld_push),
    .push_a_data ('{wa: wr.ld_wa, wd: wr.ld_wd}),
    .push_b      (mdu_push),
    .push_b_data ('{wa: wr.mdu_wa, wd: wr.mdu_wd}),
    .pop         (pop),
    .head        (fifo_head),
    .count       (fifo_count),
    .ent_valid   (ent_valid),
    .ent_wa      (ent_wa)
  );

  always_comb begin
    rf_we_d = pipe_wr || pop;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (pipe_wr) begin
      rf_wa_d = wr.pipe_wa;
      rf_wd_d = wr.pipe_wd;
    end else if (pop) begin
      rf_wa_d = fifo_head.wa;
      rf_wd_d = fifo_head.wd;
    end

    // Flag rises together with the count reaching the limit; the forced pop then clears both.
    starve_cnt_d  = (q_empty || pop) ? '0 : starve_cnt_q + 1'b1;
    starve_flag_d = (int'(starve_cnt_d) == STARVE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q       <= 1'b0;
      rf_wa_q       <= '0;
      rf_wd_q       <= '0;
      starve_cnt_q  <= '0;
      starve_flag_q <= 1'b0;
    end else begin
      rf_we_q       <= rf_we_d;
      rf_wa_q       <= rf_wa_d;
      rf_wd_q       <= rf_wd_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_flag_q <= starve_flag_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (ent_valid[i]) pending_mask = pending_mask | decode_wa(ent_wa[i]);
    end
    pending_mask[0] = 1'b0;
  end

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign q_count = fifo_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (QDEPTH=2, STARVE_MAX=4) with a falling-edge register-file model.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending_mask;
  logic [1:0]  q_count;

  logic [31:0] rf_model [32] = '{default: '0};

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (bus),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .pending_mask (pending_mask),
    .q_count      (q_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_we) rf_model[rf_wa] <= rf_wd;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.pipe_valid = v; bus.pipe_wa = wa; bus.pipe_wd = wd;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.ld_valid = v; bus.ld_wa = wa; bus.ld_wd = wd;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.mdu_valid = v; bus.mdu_wa = wa; bus.mdu_wd = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"},   rf_we,          1'b0);
    check({tag, "_rf_wa"},   rf_wa,          5'd0);
    check({tag, "_rf_wd"},   rf_wd,          32'd0);
    check({tag, "_q_count"}, q_count,        2'd0);
    check({tag, "_mask"},    pending_mask,   32'd0);
    check({tag, "_pipe_rdy"}, bus.pipe_ready, 1'b1);
    check({tag, "_ld_rdy"},  bus.ld_ready,   1'b1);
    check({tag, "_mdu_rdy"}, bus.mdu_ready,  1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_ld  (1'b0, 5'd0, 32'd0);
    drive_mdu (1'b0, 5'd0, 32'd0);
    #2;
    check_reset_outputs("por");
    #20 rst_n = 1'b1;
    tick();

    // Pipe only: one-cycle latency, committed on the falling edge.
    drive_pipe(1'b1, 5'd3, 32'h1234_5678);
    check("pipe_ready_idle", bus.pipe_ready, 1'b1);
    tick();
    check("pipe_we",  rf_we, 1'b1);
    check("pipe_wa",  rf_wa, 5'd3);
    check("pipe_wd",  rf_wd, 32'h1234_5678);
    drive_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("pipe_we_drop", rf_we, 1'b0);
    check("pipe_wa_hold", rf_wa, 5'd3);
    check("rf_read_x3",   rf_model[3], 32'h1234_5678);

    // Dual push: load lands ahead of MDU.
    drive_ld (1'b1, 5'd5, 32'h0000_AAAA);
    drive_mdu(1'b1, 5'd6, 32'h0000_BBBB);
    check("dual_ld_rdy",  bus.ld_ready,  1'b1);
    check("dual_mdu_rdy", bus.mdu_ready, 1'b1);
    tick();
    drive_ld (1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    check("dual_count", q_count,      2'd2);
    check("dual_mask",  pending_mask, 32'h60);
    check("dual_we0",   rf_we,        1'b0);
    tick();
    check("dual_w1_we", rf_we,        1'b1);
    check("dual_w1_wa", rf_wa,        5'd5);
    check("dual_w1_wd", rf_wd,        32'h0000_AAAA);
    check("dual_mask1", pending_mask, 32'h40);
    tick();
    check("dual_w2_wa", rf_wa,        5'd6);
    check("dual_w2_wd", rf_wd,        32'h0000_BBBB);
    check("dual_mask2", pending_mask, 32'h0);
    check("dual_cnt2",  q_count,      2'd0);
    tick();
    check("dual_idle",  rf_we,        1'b0);

    // Full queue: pipe keeps the port so both queued entries stay put.
    drive_pipe(1'b1, 5'd7, 32'h77);
    drive_ld  (1'b1, 5'd8, 32'h88);
    drive_mdu (1'b1, 5'd9, 32'h99);
    tick();
    drive_mdu (1'b0, 5'd0, 32'd0);
    drive_ld  (1'b1, 5'd10, 32'hA0);
    check("full_count",   q_count,       2'd2);
    check("full_pipe_wa", rf_wa,         5'd7);
    check("full_ld_rdy",  bus.ld_ready,  1'b0);
    check("full_mdu_rdy", bus.mdu_ready, 1'b0);
    tick();
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_mdu (1'b1, 5'd11, 32'hB0);
    check("fullpop_ld_rdy",  bus.ld_ready,  1'b0);
    check("fullpop_mdu_rdy", bus.mdu_ready, 1'b0);
    tick();
    check("full_w8_wa",  rf_wa,         5'd8);
    check("full_w8_wd",  rf_wd,         32'h88);
    check("full_cnt1",   q_count,       2'd1);
    check("full_mask9",  pending_mask,  32'h200);
    check("one_ld_rdy",  bus.ld_ready,  1'b1);
    check("one_mdu_rdy", bus.mdu_ready, 1'b0);
    tick();
    drive_ld (1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    check("full_w9_wa", rf_wa,        5'd9);
    check("full_cnt_b", q_count,      2'd1);
    check("full_mask10", pending_mask, 32'h400);
    tick();
    check("full_w10_wa", rf_wa,        5'd10);
    check("full_w10_wd", rf_wd,        32'hA0);
    check("full_empty",  q_count,      2'd0);

    // Starvation: one queued entry loses four cycles, then pipe is held off for one.
    drive_pipe(1'b1, 5'd12, 32'hC0);
    drive_ld  (1'b1, 5'd13, 32'hD0);
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("starve_rdy%0d", k), bus.pipe_ready, 1'b1);
      tick();
      check($sformatf("starve_wa%0d", k), rf_wa, 5'd12);
    end
    check("starve_block",  bus.pipe_ready, 1'b0);
    check("starve_mask",   pending_mask,   32'h2000);
    tick();
    check("starve_q_we",   rf_we,          1'b1);
    check("starve_q_wa",   rf_wa,          5'd13);
    check("starve_q_wd",   rf_wd,          32'hD0);
    check("starve_resume", bus.pipe_ready, 1'b1);
    check("starve_mask0",  pending_mask,   32'h0);
    tick();
    check("starve_pipe_wa", rf_wa, 5'd12);
    check("starve_pipe_wd", rf_wd, 32'hC0);
    drive_pipe(1'b0, 5'd0, 32'd0);

    // Writes to x0 are accepted and dropped.
    drive_pipe(1'b1, 5'd0, 32'hDEAD);
    drive_ld  (1'b1, 5'd0, 32'hBEEF);
    drive_mdu (1'b1, 5'd0, 32'hF00D);
    tick();
    check("x0_pipe_rdy", bus.pipe_ready, 1'b1);
    check("x0_ld_rdy",   bus.ld_ready,   1'b1);
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_ld  (1'b0, 5'd0, 32'd0);
    drive_mdu (1'b0, 5'd0, 32'd0);
    check("x0_we",   rf_we,        1'b0);
    check("x0_cnt",  q_count,      2'd0);
    check("x0_mask", pending_mask, 32'h0);
    check("x0_hold", rf_wa,        5'd12);
    tick();
    check("x0_we2",  rf_we,        1'b0);
    check("x0_rf0",  rf_model[0],  32'd0);

    // Reset with two entries queued behind a busy pipe.
    drive_pipe(1'b1, 5'd14, 32'hE0);
    drive_ld  (1'b1, 5'd15, 32'hF0);
    drive_mdu (1'b1, 5'd16, 32'h100);
    tick();
    drive_ld (1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    check("pre_rst_cnt",  q_count,      2'd2);
    check("pre_rst_mask", pending_mask, 32'h0001_8000);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    drive_pipe(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_cnt", q_count, 2'd0);
    check("post_rst_we",  rf_we,   1'b0);
    tick();
    check("post_rst_we2", rf_we,        1'b0);
    check("post_rf15",    rf_model[15], 32'd0);
    check("post_rf16",    rf_model[16], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
